// File: rtl/pwm_pkg.sv
// Shared encodings for the PWM timebase: counting modes and run-control states.
package pwm_pkg;

    typedef logic [1:0] pwm_mode_t;

    localparam pwm_mode_t MODE_UP     = 2'b00;
    localparam pwm_mode_t MODE_DOWN   = 2'b01;
    localparam pwm_mode_t MODE_UPDOWN = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

    // Down mode starts counting down; every other mode starts counting up.
    function automatic logic start_dir(input pwm_mode_t mode);
        return (mode == MODE_DOWN);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Prescaler: counts 0..i_psc and flags o_tick on the terminal count, then wraps.
module pwm_prescaler #(
    parameter int PSC_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    input  logic [PSC_WIDTH-1:0] i_psc,
    output logic                 o_tick
);

    logic [PSC_WIDTH-1:0] r_cnt;

    assign o_tick = (r_cnt == i_psc);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_timebase.sv
// PWM timebase: up/down/center-aligned counter with shadowed period, prescaler,
// repetition and mode registers, software update and one-shot stop.
//
//   state   | meaning
//   ST_IDLE | stopped; counter parked, shadows track the inputs every cycle
//   ST_RUN  | counting on prescaler ticks; shadows reload only on update events
module pwm_timebase #(
    parameter int WIDTH     = 16,
    parameter int PSC_WIDTH = 16,
    parameter int RCR_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [1:0]           i_mode,
    input  logic                 i_one_shot,
    input  logic [WIDTH-1:0]     i_arr,
    input  logic [PSC_WIDTH-1:0] i_psc,
    input  logic [RCR_WIDTH-1:0] i_rcr,
    input  logic                 i_ug,
    output logic [WIDTH-1:0]     o_cnt_val,
    output logic                 o_dir,
    output logic                 o_ovf,
    output logic                 o_udf,
    output logic                 o_uev,
    output logic                 o_running
);
    import pwm_pkg::*;

    run_state_e           r_state, w_state_next;
    logic                 r_en_d;
    logic [WIDTH-1:0]     r_arr_act, r_cnt, w_cnt_nxt;
    logic [PSC_WIDTH-1:0] r_psc_act;
    logic [RCR_WIDTH-1:0] r_rep;
    pwm_mode_t            r_mode_act;
    logic                 r_dir, r_ovf, r_udf, r_uev;
    logic                 w_dir_nxt, w_ovf_nxt, w_udf_nxt, w_period;
    logic                 w_tick, w_idle, w_rep_done, w_load;

    pwm_prescaler #(.PSC_WIDTH(PSC_WIDTH)) u_psc (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_idle || i_ug),
        .i_psc  (r_psc_act),
        .o_tick (w_tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_en_d  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_en_d  <= i_en;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (i_en && !r_en_d) w_state_next = ST_RUN;
            ST_RUN:  if (!i_en || (r_uev && i_one_shot)) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Idle values apply while parked and also on the edge that stops the counter.
    assign w_idle     = (r_state == ST_IDLE) || (w_state_next == ST_IDLE);
    assign w_rep_done = w_tick && w_period && (r_rep == '0);
    assign w_load     = w_idle || i_ug || w_rep_done;

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        w_ovf_nxt = 1'b0;
        w_udf_nxt = 1'b0;
        case (r_mode_act)
            MODE_DOWN: begin
                if (r_cnt == '0) begin
                    w_cnt_nxt = r_arr_act;
                    w_udf_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            MODE_UPDOWN: begin
                if (r_arr_act == '0) begin
                    w_cnt_nxt = '0;
                    w_dir_nxt = 1'b0;
                    w_ovf_nxt = 1'b1;
                    w_udf_nxt = 1'b1;
                end else if (!r_dir) begin
                    if (r_cnt >= r_arr_act) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                        w_dir_nxt = 1'b1;
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else if (r_cnt == '0) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    w_dir_nxt = 1'b0;
                    w_udf_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                if (r_cnt >= r_arr_act) begin
                    w_cnt_nxt = '0;
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        endcase
        w_period = (r_mode_act == MODE_DOWN || r_mode_act == MODE_UPDOWN) ? w_udf_nxt : w_ovf_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_arr_act  <= '0;
            r_psc_act  <= '0;
            r_mode_act <= MODE_UP;
        end else if (w_load) begin
            r_arr_act  <= i_arr;
            r_psc_act  <= i_psc;
            r_mode_act <= i_mode;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_dir <= 1'b0;
            r_rep <= '0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
            r_uev <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
            r_uev <= 1'b0;
            if (w_idle) begin
                r_cnt <= '0;
                r_dir <= start_dir(i_mode);
                r_rep <= i_rcr;
            end else if (i_ug) begin
                r_cnt <= (i_mode == MODE_DOWN) ? i_arr : '0;
                r_dir <= start_dir(i_mode);
                r_rep <= i_rcr;
                r_uev <= 1'b1;
            end else if (w_tick) begin
                r_cnt <= w_cnt_nxt;
                r_dir <= w_dir_nxt;
                r_ovf <= w_ovf_nxt;
                r_udf <= w_udf_nxt;
                if (w_period) begin
                    if (r_rep == '0) begin
                        r_rep <= i_rcr;
                        r_uev <= 1'b1;
                    end else begin
                        r_rep <= r_rep - 1'b1;
                    end
                end
            end
        end
    end

    assign o_cnt_val = r_cnt;
    assign o_dir     = r_dir;
    assign o_ovf     = r_ovf;
    assign o_udf     = r_udf;
    assign o_uev     = r_uev;
    assign o_running = (r_state == ST_RUN);

endmodule
